// File: rtl/crc_frame_checker_if.sv
// rtl/crc_frame_checker_if.sv - byte stream handshake bundle feeding crc_frame_checker
interface crc_frame_checker_if;
  logic       valid_i;
  logic [7:0] data_i;
  logic       last_i;
  logic       ready_o;

  modport master (output valid_i, output data_i, output last_i, input ready_o);
  modport slave  (input valid_i, input data_i, input last_i, output ready_o);
endinterface

// File: rtl/crc_frame_checker.sv
// rtl/crc_frame_checker.sv - streaming frame CRC checker: trailing CRC bytes held in a delay line
// while payload bytes feed a byte-per-cycle CRC engine; one result strobe per frame.
module crc_frame_checker #(
  parameter logic [31:0] POLY          = 32'h04C11DB7,
  parameter int          CRC_SIZE      = 32,
  parameter logic [31:0] INIT          = 32'hFFFFFFFF,
  parameter bit          REF_IN        = 1'b1,
  parameter bit          REF_OUT       = 1'b1,
  parameter logic [31:0] XOR_OUT       = 32'hFFFFFFFF,
  parameter bit          CRC_LSB_FIRST = 1'b1,
  parameter int          CNT_WIDTH     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 soft_reset_i,
  crc_frame_checker_if.slave   s_stream,
  output logic                 done_o,
  output logic                 crc_ok_o,
  output logic                 runt_o,
  output logic [CRC_SIZE-1:0]  crc_o,
  output logic [CRC_SIZE-1:0]  rx_crc_o,
  output logic [CNT_WIDTH-1:0] len_o,
  output logic [CNT_WIDTH-1:0] frame_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o
);
  localparam int                   CRC_BYTES = CRC_SIZE / 8;
  localparam logic [2:0]           FILL_FULL = 3'(CRC_BYTES);
  localparam logic [CRC_SIZE-1:0]  POLY_W    = POLY[CRC_SIZE-1:0];
  localparam logic [CRC_SIZE-1:0]  INIT_W    = INIT[CRC_SIZE-1:0];
  localparam logic [CRC_SIZE-1:0]  XOR_W     = XOR_OUT[CRC_SIZE-1:0];
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_CHECK} state_t;

  state_t                r_state, w_next;
  logic [7:0]            r_dly [CRC_BYTES];
  logic [2:0]            r_fill;
  logic [CRC_SIZE-1:0]   r_crc;
  logic [CNT_WIDTH-1:0]  r_len;
  logic                  r_done, r_ok, r_runt;
  logic [CRC_SIZE-1:0]   r_crc_out, r_rx_out;
  logic [CNT_WIDTH-1:0]  r_len_out, r_frames, r_errs;

  logic                  w_ready, w_acc, w_runt, w_ok;
  logic [CRC_SIZE-1:0]   w_crc_fin, w_crc_ref, w_rx;

  function automatic logic [CRC_SIZE-1:0] crc_step(input logic [CRC_SIZE-1:0] c, input logic [7:0] b);
    logic [CRC_SIZE-1:0] r;
    logic [7:0]          d;
    r = c;
    for (int i = 0; i < 8; i++) d[i] = REF_IN ? b[7-i] : b[i];
    for (int i = 7; i >= 0; i--) begin
      if (r[CRC_SIZE-1] ^ d[i]) r = {r[CRC_SIZE-2:0], 1'b0} ^ POLY_W;
      else                      r = {r[CRC_SIZE-2:0], 1'b0};
    end
    return r;
  endfunction

  assign w_ready           = (r_state != S_CHECK);
  assign s_stream.ready_o  = w_ready;
  assign w_acc             = s_stream.valid_i && w_ready && !soft_reset_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (soft_reset_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_acc) w_next = s_stream.last_i ? S_CHECK : S_ACC;
        S_ACC:   if (w_acc && s_stream.last_i) w_next = S_CHECK;
        S_CHECK: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Newest byte enters at the top; once the line is full, slot 0 holds the byte leaving for the engine.
  always_ff @(posedge clk_i) begin
    if (rst_i || soft_reset_i) begin
      r_fill <= '0;
      for (int i = 0; i < CRC_BYTES; i++) r_dly[i] <= '0;
      if (rst_i) begin
        r_crc <= '0;
        r_len <= '0;
      end
    end else if (w_acc) begin
      for (int i = 0; i < CRC_BYTES - 1; i++) r_dly[i] <= r_dly[i+1];
      r_dly[CRC_BYTES-1] <= s_stream.data_i;
      if (r_state == S_IDLE) begin
        r_fill <= 3'd1;
        r_crc  <= INIT_W;
        r_len  <= '0;
      end else if (r_fill == FILL_FULL) begin
        r_crc <= crc_step(r_crc, r_dly[0]);
        if (r_len != '1) r_len <= r_len + CNT_ONE;
      end else begin
        r_fill <= r_fill + 3'd1;
      end
    end else if (r_state == S_CHECK) begin
      r_fill <= '0;
      for (int i = 0; i < CRC_BYTES; i++) r_dly[i] <= '0;
    end
  end

  always_comb begin
    w_crc_ref = '0;
    w_rx      = '0;
    for (int i = 0; i < CRC_SIZE; i++) w_crc_ref[i] = REF_OUT ? r_crc[CRC_SIZE-1-i] : r_crc[i];
    for (int i = 0; i < CRC_BYTES; i++)
      w_rx[8*i +: 8] = CRC_LSB_FIRST ? r_dly[i] : r_dly[CRC_BYTES-1-i];
  end

  // No payload byte ever reached the engine means the frame was no longer than the CRC itself.
  assign w_crc_fin = w_crc_ref ^ XOR_W;
  assign w_runt    = (r_len == '0);
  assign w_ok      = !w_runt && (w_crc_fin == w_rx);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_runt    <= 1'b0;
      r_crc_out <= '0;
      r_rx_out  <= '0;
      r_len_out <= '0;
      r_frames  <= '0;
      r_errs    <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_CHECK && !soft_reset_i) begin
        r_done    <= 1'b1;
        r_ok      <= w_ok;
        r_runt    <= w_runt;
        r_crc_out <= w_crc_fin;
        r_rx_out  <= w_rx;
        r_len_out <= r_len;
        if (r_frames != '1) r_frames <= r_frames + CNT_ONE;
        if (!w_ok && r_errs != '1) r_errs <= r_errs + CNT_ONE;
      end
    end
  end

  assign done_o      = r_done;
  assign crc_ok_o    = r_ok;
  assign runt_o      = r_runt;
  assign crc_o       = r_crc_out;
  assign rx_crc_o    = r_rx_out;
  assign len_o       = r_len_out;
  assign frame_cnt_o = r_frames;
  assign err_cnt_o   = r_errs;
endmodule

// File: tb/tb_crc_frame_checker.sv
// tb/tb_crc_frame_checker.sv - randomized self-checking bench for crc_frame_checker (CRC-32 default and CRC-8 variants)
module tb_crc_frame_checker;
  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, srst, srst8;
  crc_frame_checker_if s32();
  crc_frame_checker_if s8();

  logic        done32, ok32, runt32;
  logic [31:0] crc32_o, rx32_o;
  logic [15:0] len32, fr32, er32;
  logic        done8, ok8, runt8;
  logic [7:0]  crc8_o, rx8_o;
  logic [15:0] len8, fr8, er8;

  int total = 0;
  int bad   = 0;
  int exp_fr = 0;
  int exp_er = 0;

  crc_frame_checker u_dut32 (
    .clk_i(clk), .rst_i(rst), .soft_reset_i(srst), .s_stream(s32.slave),
    .done_o(done32), .crc_ok_o(ok32), .runt_o(runt32), .crc_o(crc32_o), .rx_crc_o(rx32_o),
    .len_o(len32), .frame_cnt_o(fr32), .err_cnt_o(er32)
  );

  crc_frame_checker #(
    .POLY(32'h00000007), .CRC_SIZE(8), .INIT(32'h0), .REF_IN(1'b0), .REF_OUT(1'b0), .XOR_OUT(32'h0)
  ) u_dut8 (
    .clk_i(clk), .rst_i(rst), .soft_reset_i(srst8), .s_stream(s8.slave),
    .done_o(done8), .crc_ok_o(ok8), .runt_o(runt8), .crc_o(crc8_o), .rx_crc_o(rx8_o),
    .len_o(len8), .frame_cnt_o(fr8), .err_cnt_o(er8)
  );

  // Reflected table-free CRC-32 (right-shifting form of the standard algorithm).
  function automatic logic [31:0] ref_crc32(input bytes_t m);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (m[i]) begin
      c = c ^ {24'h0, m[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Polynomial long division of the message augmented with 8 zero bits.
  function automatic logic [7:0] ref_crc8(input bytes_t m);
    logic [8:0] rem;
    logic       inb;
    rem = '0;
    for (int i = 0; i <= m.size(); i++) begin
      for (int b = 7; b >= 0; b--) begin
        inb = (i < m.size()) ? m[i][b] : 1'b0;
        rem = {rem[7:0], inb};
        if (rem[8]) rem = rem ^ 9'h107;
      end
    end
    return rem[7:0];
  endfunction

  function automatic bytes_t known_frame(input bit corrupt);
    bytes_t f;
    f = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    if (corrupt) f[4] = 8'h36;
    return f;
  endfunction

  task automatic send32(input bytes_t f, input int max_gap, input bit use_last, input bit abort_chk,
                        output int lat, output logic rdy_chk);
    int wd;
    lat = 99;
    rdy_chk = 1'b1;
    for (int i = 0; i < f.size(); i++) begin
      @(negedge clk);
      if (max_gap > 0) begin
        s32.valid_i = 1'b0;
        s32.last_i  = 1'b0;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
      end
      s32.valid_i = 1'b1;
      s32.data_i  = f[i];
      s32.last_i  = use_last && (i == f.size() - 1);
      wd = 0;
      while (!s32.ready_o && wd < 20) begin
        @(negedge clk);
        wd++;
      end
      @(posedge clk);
    end
    if (use_last) begin
      @(negedge clk);
      s32.valid_i = 1'b0;
      s32.last_i  = 1'b0;
      rdy_chk = s32.ready_o;
      if (done32) lat = 1;
      if (abort_chk) srst = 1'b1;
      for (int k = 2; k <= 8 && lat == 99; k++) begin
        @(negedge clk);
        srst = 1'b0;
        if (done32) lat = k;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; srst = 1'b0; srst8 = 1'b0;
    s32.valid_i = 1'b0; s32.data_i = '0; s32.last_i = 1'b0;
    s8.valid_i  = 1'b0; s8.data_i  = '0; s8.last_i  = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (s32.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", s32.ready_o); end
    total++; if (done32 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done32); end
    total++; if ({ok32, runt32} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {ok32, runt32}); end
    total++; if ({crc32_o, rx32_o} !== 64'h0) begin bad++; $display("FAIL reset_crc: got %h want 0", {crc32_o, rx32_o}); end
    total++; if ({len32, fr32, er32} !== 48'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0", {len32, fr32, er32}); end
    total++; if (s8.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready8: got %b want 1", s8.ready_o); end
    rst = 1'b0;
  endtask

  task automatic test_known();
    int lat; logic rc;
    send32(known_frame(1'b0), 2, 1'b1, 1'b0, lat, rc);
    exp_fr++;
    total++; if (lat !== 2) begin bad++; $display("FAIL known_latency: got %0d want 2", lat); end
    total++; if (rc !== 1'b0) begin bad++; $display("FAIL known_ready_in_check: got %b want 0", rc); end
    total++; if (crc32_o !== 32'hCBF43926) begin bad++; $display("FAIL known_crc: got %h want cbf43926", crc32_o); end
    total++; if (rx32_o !== 32'hCBF43926) begin bad++; $display("FAIL known_rx: got %h want cbf43926", rx32_o); end
    total++; if ({ok32, runt32} !== 2'b10) begin bad++; $display("FAIL known_flags: got %b want 10", {ok32, runt32}); end
    total++; if (len32 !== 16'd9) begin bad++; $display("FAIL known_len: got %0d want 9", len32); end
    total++; if (fr32 !== 16'(exp_fr)) begin bad++; $display("FAIL known_frames: got %0d want %0d", fr32, exp_fr); end
    @(negedge clk);
    total++; if (done32 !== 1'b0) begin bad++; $display("FAIL known_done_pulse: got %b want 0", done32); end
  endtask

  task automatic test_bad_crc();
    int lat; logic rc; bytes_t f, p; logic [31:0] e;
    f = known_frame(1'b1);
    for (int i = 0; i < 9; i++) p.push_back(f[i]);
    e = ref_crc32(p);
    send32(f, 1, 1'b1, 1'b0, lat, rc);
    exp_fr++; exp_er++;
    total++; if (lat !== 2) begin bad++; $display("FAIL bad_latency: got %0d want 2", lat); end
    total++; if (ok32 !== 1'b0) begin bad++; $display("FAIL bad_ok: got %b want 0", ok32); end
    total++; if (rx32_o !== 32'hCBF43926) begin bad++; $display("FAIL bad_rx: got %h want cbf43926", rx32_o); end
    total++; if (crc32_o !== e) begin bad++; $display("FAIL bad_crc: got %h want %h", crc32_o, e); end
    total++; if (er32 !== 16'(exp_er)) begin bad++; $display("FAIL bad_errs: got %0d want %0d", er32, exp_er); end
  endtask

  task automatic test_runt();
    int lat; logic rc; bytes_t f; logic [31:0] c;
    f = {8'hAA, 8'hBB, 8'hCC};
    send32(f, 0, 1'b1, 1'b0, lat, rc);
    exp_fr++; exp_er++;
    total++; if (lat !== 2) begin bad++; $display("FAIL runt3_latency: got %0d want 2", lat); end
    total++; if ({ok32, runt32} !== 2'b01) begin bad++; $display("FAIL runt3_flags: got %b want 01", {ok32, runt32}); end
    total++; if (len32 !== 16'd0) begin bad++; $display("FAIL runt3_len: got %0d want 0", len32); end
    total++; if (er32 !== 16'(exp_er)) begin bad++; $display("FAIL runt3_errs: got %0d want %0d", er32, exp_er); end
    f = {8'h5A};
    send32(f, 0, 1'b1, 1'b0, lat, rc);
    exp_fr++; exp_er++;
    total++; if (lat !== 2) begin bad++; $display("FAIL runt1_latency: got %0d want 2", lat); end
    total++; if ({ok32, runt32} !== 2'b01) begin bad++; $display("FAIL runt1_flags: got %b want 01", {ok32, runt32}); end
    f = {8'h42};
    c = ref_crc32(f);
    f.push_back(c[7:0]); f.push_back(c[15:8]); f.push_back(c[23:16]); f.push_back(c[31:24]);
    send32(f, 0, 1'b1, 1'b0, lat, rc);
    exp_fr++;
    total++; if ({ok32, runt32} !== 2'b10) begin bad++; $display("FAIL min_frame_flags: got %b want 10", {ok32, runt32}); end
    total++; if (len32 !== 16'd1) begin bad++; $display("FAIL min_frame_len: got %0d want 1", len32); end
    total++; if ({fr32, er32} !== {16'(exp_fr), 16'(exp_er)}) begin bad++; $display("FAIL runt_counts: got %0d/%0d want %0d/%0d", fr32, er32, exp_fr, exp_er); end
  endtask

  task automatic test_soft_abort();
    int lat; logic rc; bytes_t f;
    f = {8'h10, 8'h20, 8'h30, 8'h40};
    send32(f, 0, 1'b0, 1'b0, lat, rc);
    @(negedge clk);
    srst = 1'b1; s32.valid_i = 1'b1; s32.data_i = 8'h55; s32.last_i = 1'b1;
    @(negedge clk);
    srst = 1'b0; s32.valid_i = 1'b0; s32.last_i = 1'b0;
    total++; if (done32 !== 1'b0) begin bad++; $display("FAIL soft_no_done: got %b want 0", done32); end
    send32(known_frame(1'b0), 1, 1'b1, 1'b0, lat, rc);
    exp_fr++;
    total++; if (lat !== 2) begin bad++; $display("FAIL soft_latency: got %0d want 2", lat); end
    total++; if (ok32 !== 1'b1) begin bad++; $display("FAIL soft_ok: got %b want 1", ok32); end
    total++; if (fr32 !== 16'(exp_fr)) begin bad++; $display("FAIL soft_frames: got %0d want %0d", fr32, exp_fr); end
  endtask

  task automatic test_soft_in_check();
    int lat; logic rc;
    send32(known_frame(1'b1), 0, 1'b1, 1'b1, lat, rc);
    total++; if (lat !== 99) begin bad++; $display("FAIL chk_abort_done: got latency %0d want none", lat); end
    total++; if ({fr32, er32} !== {16'(exp_fr), 16'(exp_er)}) begin bad++; $display("FAIL chk_abort_counts: got %0d/%0d want %0d/%0d", fr32, er32, exp_fr, exp_er); end
    total++; if (ok32 !== 1'b1) begin bad++; $display("FAIL chk_abort_held_ok: got %b want 1", ok32); end
    total++; if (rx32_o !== 32'hCBF43926) begin bad++; $display("FAIL chk_abort_held_rx: got %h want cbf43926", rx32_o); end
  endtask

  task automatic test_random();
    int lat, n, L; logic rc; bytes_t f, p; logic [31:0] c, rx_e; bit runt_e, ok_e;
    for (int t = 0; t < 14; t++) begin
      f = {};
      n = $urandom_range(0, 12);
      if (n == 0) begin
        repeat ($urandom_range(1, 4)) f.push_back(8'($urandom));
      end else begin
        repeat (n) f.push_back(8'($urandom));
        c = ref_crc32(f);
        f.push_back(c[7:0]); f.push_back(c[15:8]); f.push_back(c[23:16]); f.push_back(c[31:24]);
        if ($urandom_range(0, 2) == 0) f[$urandom_range(0, f.size() - 1)] ^= 8'h01 << $urandom_range(0, 7);
      end
      L = f.size();
      runt_e = (L <= 4);
      p = {};
      for (int i = 0; i < L - 4; i++) p.push_back(f[i]);
      c = ref_crc32(p);
      rx_e = (L >= 4) ? {f[L-1], f[L-2], f[L-3], f[L-4]} : 32'h0;
      ok_e = !runt_e && (c == rx_e);
      send32(f, 3, 1'b1, 1'b0, lat, rc);
      exp_fr++;
      if (!ok_e) exp_er++;
      total++; if (lat !== 2) begin bad++; $display("FAIL rnd%0d_latency: got %0d want 2", t, lat); end
      total++; if ({ok32, runt32} !== {ok_e, runt_e}) begin bad++; $display("FAIL rnd%0d_flags: got %b want %b", t, {ok32, runt32}, {ok_e, runt_e}); end
      total++; if (len32 !== (runt_e ? 16'd0 : 16'(L - 4))) begin bad++; $display("FAIL rnd%0d_len: got %0d want %0d", t, len32, runt_e ? 0 : L - 4); end
      if (!runt_e) begin
        total++; if ({crc32_o, rx32_o} !== {c, rx_e}) begin bad++; $display("FAIL rnd%0d_crc: got %h/%h want %h/%h", t, crc32_o, rx32_o, c, rx_e); end
      end
      total++; if ({fr32, er32} !== {16'(exp_fr), 16'(exp_er)}) begin bad++; $display("FAIL rnd%0d_counts: got %0d/%0d want %0d/%0d", t, fr32, er32, exp_fr, exp_er); end
    end
  endtask

  task automatic test_crc8_back_to_back();
    bytes_t s, p; bit lf[$]; logic [7:0] e[2]; int idx, lows, dones, cyc, tail;
    s = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    for (int i = 0; i < 10; i++) lf.push_back(i == 9);
    e[0] = 8'hF4;
    repeat (5) p.push_back(8'($urandom));
    e[1] = ref_crc8(p);
    foreach (p[i]) begin s.push_back(p[i]); lf.push_back(1'b0); end
    s.push_back(e[1]); lf.push_back(1'b1);
    idx = 0; lows = 0; dones = 0; cyc = 0; tail = 0;
    @(negedge clk);
    while (cyc < 100 && tail < 4) begin
      if (idx < s.size()) begin
        s8.valid_i = 1'b1; s8.data_i = s[idx]; s8.last_i = lf[idx];
      end else begin
        s8.valid_i = 1'b0; s8.last_i = 1'b0; tail++;
      end
      if (!s8.ready_o) lows++;
      if (done8) begin
        if (dones < 2) begin
          total++; if ({ok8, crc8_o} !== {1'b1, e[dones]}) begin bad++; $display("FAIL crc8_frame%0d: got ok=%b crc=%h want ok=1 crc=%h", dones, ok8, crc8_o, e[dones]); end
        end
        dones++;
      end
      if (idx < s.size() && s8.ready_o) idx++;
      @(negedge clk);
      cyc++;
    end
    total++; if (lows !== 2) begin bad++; $display("FAIL crc8_ready_low: got %0d want 2", lows); end
    total++; if (dones !== 2) begin bad++; $display("FAIL crc8_dones: got %0d want 2", dones); end
    total++; if ({fr8, len8} !== {16'd2, 16'd5}) begin bad++; $display("FAIL crc8_counts: got %0d/%0d want 2/5", fr8, len8); end
  endtask

  task automatic test_mid_reset();
    int lat; logic rc; bytes_t f;
    f = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send32(f, 0, 1'b0, 1'b0, lat, rc);
    @(negedge clk);
    rst = 1'b1; s32.valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_fr = 0; exp_er = 0;
    total++; if ({done32, ok32, runt32} !== 3'b000) begin bad++; $display("FAIL mid_rst_flags: got %b want 000", {done32, ok32, runt32}); end
    total++; if ({crc32_o, rx32_o, len32, fr32, er32} !== 112'h0) begin bad++; $display("FAIL mid_rst_values: got %h want 0", {crc32_o, rx32_o, len32, fr32, er32}); end
    send32(known_frame(1'b0), 0, 1'b1, 1'b0, lat, rc);
    exp_fr++;
    total++; if (lat !== 2) begin bad++; $display("FAIL mid_rst_latency: got %0d want 2", lat); end
    total++; if ({ok32, fr32} !== {1'b1, 16'(exp_fr)}) begin bad++; $display("FAIL mid_rst_result: got ok=%b frames=%0d want ok=1 frames=%0d", ok32, fr32, exp_fr); end
  endtask

  initial begin
    test_reset();
    test_known();
    test_bad_crc();
    test_runt();
    test_soft_abort();
    test_soft_in_check();
    test_random();
    test_crc8_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/crc_frame_checker.md
CRC_FRAME_CHECKER -- requirements
Module: crc_frame_checker

Interface
REQ-001 SHALL have parameter POLY, default 32'h04C11DB7: generator polynomial, implicit top bit omitted.
REQ-002 SHALL have parameter CRC_SIZE, default 32: CRC width, one of 8/16/32; CRC_BYTES = CRC_SIZE/8.
REQ-003 SHALL have parameter INIT, default 32'hFFFFFFFF: register preset at frame start.
REQ-004 SHALL have parameters REF_IN (default 1), REF_OUT (default 1), XOR_OUT (default 32'hFFFFFFFF): input-byte reflection, output reflection, final XOR.
REQ-005 SHALL have parameter CRC_LSB_FIRST, default 1: 1 = transmitted CRC arrives least-significant byte first, 0 = most-significant byte first.
REQ-006 SHALL have parameter CNT_WIDTH, default 16: width of the length and statistics counters.
REQ-007 SHALL have ports clk_i in 1 (single clock); rst_i in 1 (synchronous, active-high reset).
REQ-008 SHALL have ports soft_reset_i in 1 (frame abort); valid_i in 1; data_i in 8; last_i in 1 (final byte of frame); ready_o out 1.
REQ-009 SHALL have ports done_o out 1 (one-cycle result strobe); crc_ok_o out 1; runt_o out 1; crc_o out CRC_SIZE (computed CRC); rx_crc_o out CRC_SIZE (received CRC).
REQ-010 SHALL have ports len_o out CNT_WIDTH (payload byte count); frame_cnt_o out CNT_WIDTH; err_cnt_o out CNT_WIDTH.

Function
REQ-011 SHALL accept a byte on every rising edge with valid_i && ready_o; bytes offered while ready_o=0 are not consumed and the source holds them.
REQ-012 SHALL treat the last CRC_BYTES bytes of each frame as the received CRC and all preceding bytes as payload.
REQ-013 SHALL route accepted bytes through a CRC_BYTES-deep delay line; once full, each new byte pushes the oldest byte into the CRC engine, processing one byte per cycle.
REQ-014 SHALL implement FSM states IDLE, ACC, CHECK: IDLE->ACC on the first accepted byte without last_i; IDLE/ACC->CHECK on an accepted byte with last_i; CHECK->IDLE unconditionally after one cycle.
REQ-015 SHALL hold ready_o=0 only in CHECK (exactly one cycle per frame) and ready_o=1 in IDLE and ACC.
REQ-016 SHALL preset the CRC register to INIT on entry into ACC or CHECK from IDLE; engine is MSB-first shift with POLY, byte bit-reversed first when REF_IN=1.
REQ-017 SHALL form crc_o as the register bit-reversed when REF_OUT=1, then XORed with XOR_OUT.
REQ-018 SHALL assemble rx_crc_o from the delay line per CRC_LSB_FIRST.
REQ-019 SHALL, for a last byte accepted in cycle N, be in CHECK in cycle N+1 and present done_o=1 for exactly cycle N+2, with crc_ok_o, runt_o, crc_o, rx_crc_o, len_o valid from N+2 and held until the next done_o.
REQ-020 SHALL set crc_ok_o=1 iff runt_o=0 and crc_o==rx_crc_o.
REQ-021 SHALL flag runt_o=1, crc_ok_o=0 for frames of total length <= CRC_BYTES (including a single-byte frame with last_i in IDLE).
REQ-022 SHALL accept a frame of exactly CRC_BYTES+1 bytes as valid (one payload byte).
REQ-023 SHALL report len_o = total bytes - CRC_BYTES (0 for runts), saturating at all-ones.
REQ-024 SHALL increment frame_cnt_o on every done_o and err_cnt_o on every done_o with crc_ok_o=0; both saturate at all-ones.
REQ-025 SHALL, on soft_reset_i=1, return to IDLE, empty the delay line and discard the partial frame without done_o; the coincident byte is dropped; result outputs and counters keep their values.
REQ-026 SHALL give soft_reset_i priority over valid_i/last_i in the same cycle, including during CHECK (pending result discarded, no done_o, counters unchanged).

Reset
REQ-027 SHALL, with rst_i=1 at a rising edge, enter IDLE, empty the delay line, and drive ready_o=1 and done_o=0, crc_ok_o=0, runt_o=0, crc_o=0, rx_crc_o=0, len_o=0, frame_cnt_o=0, err_cnt_o=0 from the following cycle.
REQ-028 SHALL give rst_i priority over soft_reset_i and all stream inputs; reset mid-frame discards the frame with no done_o.

Verification
REQ-029 Defaults, "123456789" (31..39) then 26 39 F4 CB, last_i on CB -> done_o two cycles later, crc_o=rx_crc_o=32'hCBF43926, crc_ok_o=1, len_o=9, frame_cnt_o=1.
REQ-030 Same frame with byte 35 replaced by 36 -> crc_ok_o=0, rx_crc_o=32'hCBF43926, crc_o differs, err_cnt_o=1.
REQ-031 CRC_SIZE=8, POLY=8'h07, INIT=0, REF_IN=REF_OUT=0, XOR_OUT=0: "123456789" then F4 -> crc_o=8'hF4, crc_ok_o=1; valid_i held high across frames shows exactly one ready_o=0 cycle each.
REQ-032 Defaults, 3-byte frame AA BB CC with last_i -> runt_o=1, crc_ok_o=0, len_o=0, err_cnt_o increments; 5-byte frame of one payload byte plus correct CRC -> crc_ok_o=1, len_o=1.
REQ-033 soft_reset_i pulsed after 4 bytes of a frame, then the REQ-029 frame -> single done_o with crc_ok_o=1; frame_cnt_o increments by one only.
REQ-034 rst_i asserted for one cycle mid-frame, then the REQ-029 frame -> all outputs zero after reset, then crc_ok_o=1, frame_cnt_o=1.
